// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Data-hazard and branch-flush controller for a 5-stage MIPS-style pipeline.
// Decoded destinations of issued instructions move through a 3-slot
// scoreboard (EXE, MEM, WB). The instruction in decode is compared against
// that scoreboard, and the result drives stall, bubble and flush.
//
// Optional feature macro: HAZARD_FWD_EN
//   defined   : only a load in EXE with a matching destination causes a hazard
//               (load-use, one bubble). Forwarding resolves other matches.
//   undefined : any valid EXE/MEM/WB slot with a matching destination causes a
//               hazard (full interlock, up to three bubbles).
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   instr_id   in   instruction in decode (32'd0 is a NOP)
//   id_valid   in   instr_id is a real instruction
//   branch     in   registered taken-branch flag from execute
//   stall      out  hold PC and IF/ID (combinational)
//   bubble     out  load 32'd0 into ID/EXE (combinational)
//   flush      out  load 32'd0 into IF/ID (combinational)
//   state      out  registered controller state: RUN=00, STALL=01, FLUSH=10
//   stall_cnt  out  saturating count of stall cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instr_id,
    input  logic                   id_valid,
    input  logic                   branch,
    output logic                   stall,
    output logic                   bubble,
    output logic                   flush,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, dest: 5'd0, is_load: 1'b0};
    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    slot_t                   exe_r;
    slot_t                   mem_r;
    slot_t                   wb_r;
    state_t                  state_r;
    logic [STALL_CNT_W-1:0]  stall_cnt_r;
    logic                    hazard_s;
    logic                    stall_s;
    logic                    bubble_s;
    logic                    flush_s;

    // Destination decode; the all-zero word is a NOP and writes nothing.
    function automatic slot_t decode_dest(input logic [31:0] instr);
        slot_t s;
        s = SLOT_EMPTY;
        case (instr[31:26])
            6'd0: begin
                if (instr != 32'd0) begin
                    s.valid = 1'b1;
                    s.dest  = instr[15:11];
                end else begin
                    s = SLOT_EMPTY;
                end
            end
            6'd35: begin
                s.valid   = 1'b1;
                s.dest    = instr[20:16];
                s.is_load = 1'b1;
            end
            6'd8: begin
                s.valid = 1'b1;
                s.dest  = instr[20:16];
            end
            default: s = SLOT_EMPTY;
        endcase
        return s;
    endfunction

    function automatic logic reads_rs(input logic [5:0] op);
        logic r;
        case (op)
            6'd0, 6'd35, 6'd43, 6'd8, 6'd4, 6'd5: r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic reads_rt(input logic [5:0] op);
        logic r;
        case (op)
            6'd0, 6'd43, 6'd4, 6'd5: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

    // A slot matches when it holds a real, non-$0 destination read by decode.
    function automatic logic slot_hit(input slot_t s, input logic [31:0] instr);
        logic use_rs;
        logic use_rt;
        use_rs = reads_rs(instr[31:26]);
        use_rt = reads_rt(instr[31:26]);
        return s.valid && (s.dest != 5'd0) &&
               ((use_rs && (instr[25:21] == s.dest)) ||
                (use_rt && (instr[20:16] == s.dest)));
    endfunction

    // Hazard detection against the scoreboard.
    always_comb begin
        hazard_s = 1'b0;
`ifdef HAZARD_FWD_EN
        hazard_s = id_valid && exe_r.is_load && slot_hit(exe_r, instr_id);
`else
        hazard_s = id_valid && (slot_hit(exe_r, instr_id) ||
                                slot_hit(mem_r, instr_id) ||
                                slot_hit(wb_r,  instr_id));
`endif
    end

    // Pipeline control; a taken branch overrides any stall.
    always_comb begin
        flush_s  = branch;
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        if (branch) begin
            bubble_s = 1'b1;
        end else if (hazard_s) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
        end else begin
            stall_s  = 1'b0;
            bubble_s = 1'b0;
        end
    end

    // Scoreboard shift; a branch kills the instruction that followed it into EXE.
    always_ff @(posedge clk) begin
        if (reset) begin
            exe_r <= SLOT_EMPTY;
            mem_r <= SLOT_EMPTY;
            wb_r  <= SLOT_EMPTY;
        end else begin
            wb_r  <= mem_r;
            mem_r <= branch ? SLOT_EMPTY : exe_r;
            if (id_valid && !stall_s && !flush_s) begin
                exe_r <= decode_dest(instr_id);
            end else begin
                exe_r <= SLOT_EMPTY;
            end
        end
    end

    // Controller state and saturating stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_RUN;
            stall_cnt_r <= '0;
        end else begin
            if (branch) begin
                state_r <= ST_FLUSH;
            end else if (stall_s) begin
                state_r <= ST_STALL;
            end else begin
                state_r <= ST_RUN;
            end
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign stall     = stall_s;
    assign bubble    = bubble_s;
    assign flush     = flush_s;
    assign state     = state_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. A default-width instance covers the main
// behaviour; a second instance with a 4-bit counter shares the same stimulus
// and covers counter saturation. Expected values depend on HAZARD_FWD_EN.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [31:0] ADD_A   = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] ADD_B   = 32'h0064_2820; // add $5,$3,$4
    localparam logic [31:0] LW_2    = 32'h8C22_0000; // lw  $2,0($1)
    localparam logic [31:0] ADD_LU  = 32'h0042_2020; // add $4,$2,$2
    localparam logic [31:0] ADDI_0  = 32'h2020_0005; // addi $0,$1,5
    localparam logic [31:0] ADD_Z   = 32'h0000_1020; // add $2,$0,$0
    localparam logic [31:0] LW_SELF = 32'h8C63_0000; // lw  $3,0($3)

`ifdef HAZARD_FWD_EN
    localparam int AA_STALLS  = 0;
    localparam int LU_STALLS  = 1;
    localparam int SELF_TOTAL = 20;  // one stall every other cycle over 40 cycles
`else
    localparam int AA_STALLS  = 3;
    localparam int LU_STALLS  = 3;
    localparam int SELF_TOTAL = 30;  // three stalls every four cycles over 40 cycles
`endif

    logic        clk;
    logic        reset;
    logic [31:0] instr_id;
    logic        id_valid;
    logic        branch;
    logic        stall, bubble, flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic        stall4, bubble4, flush4;
    logic [1:0]  state4;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    hazard_ctrl #(.STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .instr_id(instr_id), .id_valid(id_valid),
        .branch(branch), .stall(stall), .bubble(bubble), .flush(flush),
        .state(state), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.STALL_CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .instr_id(instr_id), .id_valid(id_valid),
        .branch(branch), .stall(stall4), .bubble(bubble4), .flush(flush4),
        .state(state4), .stall_cnt(stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drain();
        id_valid = 1'b0;
        branch   = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        reset = 1'b1; id_valid = 1'b0; branch = 1'b0; instr_id = 32'd0;
        tick(); tick();
        reset = 1'b0; #1;
        chk("rst_state",  {30'd0, state}, 32'd0);
        chk("rst_cnt",    {16'd0, stall_cnt}, 32'd0);
        chk("rst_stall",  {31'd0, stall}, 32'd0);
        chk("rst_bubble", {31'd0, bubble}, 32'd0);
        chk("rst_flush",  {31'd0, flush}, 32'd0);

        // add -> dependent add
        instr_id = ADD_A; id_valid = 1'b1; #1;
        chk("aa_first_nostall", {31'd0, stall}, 32'd0);
        tick();
        instr_id = ADD_B; #1;
        for (int i = 0; i < AA_STALLS; i++) begin
            chk("aa_stall",  {31'd0, stall}, 32'd1);
            chk("aa_bubble", {31'd0, bubble}, 32'd1);
            tick();
        end
        exp_cnt += AA_STALLS;
        chk("aa_release", {31'd0, stall}, 32'd0);
        chk("aa_cnt", {16'd0, stall_cnt}, exp_cnt);
        chk("aa_state", {30'd0, state}, (AA_STALLS > 0) ? 32'd1 : 32'd0);
        tick();
        drain();

        // load -> use
        instr_id = LW_2; id_valid = 1'b1;
        tick();
        instr_id = ADD_LU; #1;
        for (int i = 0; i < LU_STALLS; i++) begin
            chk("lu_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        exp_cnt += LU_STALLS;
        chk("lu_release", {31'd0, stall}, 32'd0);
        chk("lu_cnt", {16'd0, stall_cnt}, exp_cnt);
        tick();
        drain();

        // id_valid=0 suppresses outputs even with a dependent word in decode
        instr_id = ADD_A; id_valid = 1'b1;
        tick();
        instr_id = ADD_B; id_valid = 1'b0; #1;
        chk("idv0_stall",  {31'd0, stall}, 32'd0);
        chk("idv0_bubble", {31'd0, bubble}, 32'd0);
        chk("idv0_flush",  {31'd0, flush}, 32'd0);
        drain();

        // $0 destination never stalls
        instr_id = ADDI_0; id_valid = 1'b1; #1;
        chk("r0_stall_a", {31'd0, stall}, 32'd0);
        tick();
        instr_id = ADD_Z; #1;
        for (int i = 0; i < 3; i++) begin
            chk("r0_stall_b", {31'd0, stall}, 32'd0);
            tick();
        end
        chk("r0_cnt", {16'd0, stall_cnt}, exp_cnt);
        drain();

        // branch while decode is dependent
        instr_id = ADD_A; id_valid = 1'b1;
        tick();
        instr_id = ADD_B; branch = 1'b1; #1;
        chk("br_flush",  {31'd0, flush}, 32'd1);
        chk("br_bubble", {31'd0, bubble}, 32'd1);
        chk("br_stall",  {31'd0, stall}, 32'd0);
        tick();
        branch = 1'b0; #1;
        chk("br_state", {30'd0, state}, 32'd2);
        chk("br_mem_invalid", {31'd0, dut.mem_r.valid}, 32'd0);
        chk("br_after_nostall", {31'd0, stall}, 32'd0);
        chk("br_after_flush", {31'd0, flush}, 32'd0);
        tick();
        drain();

        // reset during a pending stall
        instr_id = LW_2; id_valid = 1'b1;
        tick();
        instr_id = ADD_LU; #1;
        chk("rms_stall", {31'd0, stall}, 32'd1);
        tick();
        reset = 1'b1; branch = 1'b1; #1;
        chk("rms_flush_pass", {31'd0, flush}, 32'd1);
        tick();
        reset = 1'b0; branch = 1'b0; #1;
        chk("rms_stall_after", {31'd0, stall}, 32'd0);
        chk("rms_state", {30'd0, state}, 32'd0);
        chk("rms_cnt",   {16'd0, stall_cnt}, 32'd0);
        chk("rms_cnt4",  {28'd0, stall_cnt4}, 32'd0);
        drain();

        // counter saturation with a self-dependent load
        reset = 1'b1;
        tick();
        reset = 1'b0;
        instr_id = LW_SELF; id_valid = 1'b1;
        repeat (40) tick();
        chk("sat_cnt16", {16'd0, stall_cnt}, SELF_TOTAL);
        chk("sat_cnt4",  {28'd0, stall_cnt4}, 32'd15);
        drain();
        chk("sat_hold4", {28'd0, stall_cnt4}, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
